synth_clock_divider: RTL and testbench
======================================

SYNTH_CLOCK_DIVIDER -- requirements
Module: synthClockDivider

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of the HighTicks/LowTicks phase-length inputs and of the internal down-counter.
REQ-002 Port FPGAClock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1, synchronous, active-high reset.
REQ-004 Port Mode, input, 2, run control: 00 STOP, 01 RUN, 10 STEP, 11 reserved and treated as STOP.
REQ-005 Port HighTicks, input, CNT_WIDTH, length of the high phase in FPGAClock cycles.
REQ-006 Port LowTicks, input, CNT_WIDTH, length of the low phase in FPGAClock cycles.
REQ-007 Port StepReq, input, 1, level sampled each cycle; requests one high pulse in STEP mode.
REQ-008 Port SynthesizedClock, output, 1, registered divided clock.
REQ-009 Port RiseTick, output, 1, registered; high for exactly the first cycle of each high phase.
REQ-010 Port FallTick, output, 1, registered; high for exactly the first cycle after each high phase ends.
REQ-011 Port Running, output, 1, registered; high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement three states: IDLE (output low, parked), HIGH, and LOW.
REQ-013 The effective phase length SHALL be max(HighTicks,1) for HIGH and max(LowTicks,1) for LOW, so an input value of 0 behaves as 1.
REQ-014 On each entry to HIGH or LOW, the counter SHALL load (effective length - 1), sampling HighTicks or LowTicks only at that load.
REQ-015 In HIGH or LOW, the counter SHALL decrement by 1 each cycle while it is nonzero; phase exit occurs on the edge where the counter equals 0.
REQ-016 IDLE -> HIGH SHALL occur when Mode=RUN, or when Mode=STEP and StepReq=1.
REQ-017 In all other cases, IDLE SHALL remain in IDLE.
REQ-018 HIGH with counter=0 SHALL go to LOW if Mode=RUN, otherwise to IDLE.
REQ-019 A HIGH phase SHALL never be truncated by a Mode change.
REQ-020 LOW with counter=0 and Mode=RUN SHALL go to HIGH.
REQ-021 LOW with Mode!=RUN SHALL go to IDLE on the next edge regardless of the counter value, with no tick.
REQ-022 In RUN, the period SHALL be effective high length + effective low length, and the duty cycle SHALL be exactly as programmed.
REQ-023 SynthesizedClock SHALL be 1 exactly in cycles where the state is HIGH, with no combinational path from any input.
REQ-024 RiseTick SHALL assert in the same cycle SynthesizedClock goes 0->1.
REQ-025 FallTick SHALL assert in the same cycle SynthesizedClock goes 1->0.
REQ-026 RiseTick and FallTick SHALL never be high together.
REQ-027 StepReq SHALL be ignored outside IDLE, so a held or repeated StepReq during a STEP pulse does not extend that pulse.
REQ-028 If StepReq is held high in STEP mode, one pulse SHALL follow another, with HIGH returning to IDLE for one cycle between pulses.
REQ-029 Changes to HighTicks or LowTicks during a phase SHALL NOT affect that phase; the new value takes effect at the next load.
REQ-030 All arithmetic SHALL be unsigned CNT_WIDTH with no wrap, since decrement is gated by counter!=0.

Reset
REQ-031 While Reset=1 at an edge, the state SHALL become IDLE and the counter 0.
REQ-032 While Reset=1 at an edge, SynthesizedClock, RiseTick, FallTick and Running SHALL all become 0, regardless of Mode and StepReq.
REQ-033 Reset asserted mid-HIGH SHALL force the output low on the next edge without asserting FallTick.
REQ-034 After Reset deasserts, behaviour SHALL resume from IDLE per REQ-016.

Verification
REQ-035 Scenario: CNT_WIDTH=16, H=2, L=3, Mode=RUN after reset -> SynthesizedClock 1,1,0,0,0 repeating (period 5); RiseTick every 5th cycle; FallTick 2 cycles after each RiseTick.
REQ-036 Scenario: H=0, L=0, RUN -> SynthesizedClock toggles every cycle (period 2); RiseTick and FallTick alternate each cycle.
REQ-037 Scenario: Mode=STEP, H=4, StepReq held 1 cycle -> exactly 4 high cycles, then FallTick, then IDLE with Running=0. A StepReq pulse during those 4 cycles -> no extra pulse.
REQ-038 Scenario: RUN with H=8, Mode switched to STOP 3 cycles into HIGH -> high completes all 8 cycles, FallTick fires, Running=0.
REQ-039 Scenario: Mode switched to STOP during LOW -> IDLE next edge with no tick.
REQ-040 Scenario: Reset asserted 2 cycles into a HIGH phase of H=5 -> next cycle all outputs 0 with no FallTick. After release with RUN -> RiseTick on the first edge.
REQ-041 Scenario: H changed 3->6 mid-HIGH -> current high lasts 3 cycles; the next high lasts 6 cycles.

Source files
------------

// File: rtl/synth_clock_divider.sv
// Programmable clock synthesiser: HIGH/LOW phase lengths in FPGAClock cycles, with RUN/STOP/STEP control.
// Latency: every output is registered; a start request shows up on the outputs after one edge.
// Backpressure: none. StepReq is only looked at in IDLE, and a HIGH phase always runs to completion.
//
// Ports:
//   FPGAClock        - sole clock; all state updates on its rising edge
//   Reset            - synchronous, active-high
//   Mode[1:0]        - 00 STOP, 01 RUN, 10 STEP, 11 reserved (behaves as STOP)
//   HighTicks        - high phase length; 0 behaves as 1; sampled only when the phase loads
//   LowTicks         - low phase length; 0 behaves as 1; sampled only when the phase loads
//   StepReq          - level; in STEP mode, requests one high pulse while IDLE
//   SynthesizedClock - high exactly while the state is HIGH
//   RiseTick         - first cycle of each high phase
//   FallTick         - first cycle after each high phase ends
//   Running          - high whenever the state is not IDLE
module synth_clock_divider #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 FPGAClock,
  input  logic                 Reset,
  input  logic [1:0]           Mode,
  input  logic [CNT_WIDTH-1:0] HighTicks,
  input  logic [CNT_WIDTH-1:0] LowTicks,
  input  logic                 StepReq,
  output logic                 SynthesizedClock,
  output logic                 RiseTick,
  output logic                 FallTick,
  output logic                 Running
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   run_q, run_d;

  logic                   mode_run;
  logic                   start_req;
  logic                   cnt_zero;
  logic [CNT_WIDTH-1:0]   high_load;
  logic [CNT_WIDTH-1:0]   low_load;

  // A programmed length of 0 behaves as 1, so the load value is max(len,1)-1.
  // Gating the subtraction on nonzero keeps the arithmetic from wrapping.
  always_comb begin
    high_load = (HighTicks == '0) ? '0 : HighTicks - CNT_WIDTH'(1);
    low_load  = (LowTicks  == '0) ? '0 : LowTicks  - CNT_WIDTH'(1);
    mode_run  = (Mode == MODE_RUN);
    start_req = mode_run || ((Mode == MODE_STEP) && StepReq);
    cnt_zero  = (cnt_q == '0);
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_req) begin
          state_d = ST_HIGH;
          cnt_d   = high_load;
        end
      end
      ST_HIGH: begin
        // A mode change is only looked at once the high phase is complete,
        // so a pulse is never cut short.
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else if (mode_run) begin
          state_d = ST_LOW;
          cnt_d   = low_load;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        // Leaving RUN abandons the low phase at once; the output is already low.
        if (!mode_run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          state_d = ST_HIGH;
          cnt_d   = high_load;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register; nothing combinational reaches the output pins.
  always_comb begin
    sclk_d = (state_d == ST_HIGH);
    rise_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    fall_d = (state_q == ST_HIGH) && (state_d != ST_HIGH);
    run_d  = (state_d != ST_IDLE);
  end

  // Reset clears the output registers directly, so a reset during HIGH drops
  // the clock without producing a FallTick.
  always_ff @(posedge FPGAClock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      run_q   <= run_d;
    end
  end

  assign SynthesizedClock = sclk_q;
  assign RiseTick         = rise_q;
  assign FallTick         = fall_q;
  assign Running          = run_q;

endmodule

// File: tb/tb_synth_clock_divider.sv
// Directed bench for synth_clock_divider. Each stimulus cycle pushes the
// hand-computed {clk,rise,fall,running} expected after the next edge; the
// monitor pops and compares one entry per edge.
module tb_synth_clock_divider;

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] high_ticks;
  logic [15:0] low_ticks;
  logic        step_req;
  logic        sclk;
  logic        rise;
  logic        fall;
  logic        running;

  logic [3:0]  exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passed = 0;

  synth_clock_divider #(.CNT_WIDTH(16)) dut (
    .FPGAClock        (clk),
    .Reset            (rst),
    .Mode             (mode),
    .HighTicks        (high_ticks),
    .LowTicks         (low_ticks),
    .StepReq          (step_req),
    .SynthesizedClock (sclk),
    .RiseTick         (rise),
    .FallTick         (fall),
    .Running          (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge; e = {clk,rise,fall,running}
  // expected after the following rising edge.
  task automatic cyc(input logic r, input logic [1:0] m, input logic s,
                     input logic [15:0] h, input logic [15:0] l,
                     input logic [3:0] e, input string n);
    @(negedge clk);
    rst        = r;
    mode       = m;
    step_req   = s;
    high_ticks = h;
    low_ticks  = l;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: one output sample per rising edge, taken 1 time unit after it.
  initial begin
    logic [3:0] act;
    logic [3:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {sclk, rise, fall, running};
        checks++;
        if (act === e && !(rise && fall)) begin
          passed++;
        end else begin
          $display("FAIL %s: got clk/rise/fall/run=%b, expected %b", n, act, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] pat35[5];
    int         wait_cycles;
    pat35[0] = 4'b1101;
    pat35[1] = 4'b1001;
    pat35[2] = 4'b0011;
    pat35[3] = 4'b0001;
    pat35[4] = 4'b0001;

    rst = 1'b1; mode = RUN; step_req = 1'b1; high_ticks = 16'd2; low_ticks = 16'd3;

    // Reset overrides RUN and StepReq
    cyc(1'b1, RUN,  1'b1, 16'd2, 16'd3, 4'b0000, "reset_run");
    cyc(1'b1, STEP, 1'b1, 16'd2, 16'd3, 4'b0000, "reset_step");

    // H=2, L=3 RUN: period 5, pattern 1,1,0,0,0
    for (int k = 0; k < 10; k++)
      cyc(1'b0, RUN, 1'b0, 16'd2, 16'd3, pat35[k % 5], $sformatf("run_h2l3_%0d", k));
    // STOP in LOW with counter already 0
    cyc(1'b0, STOP, 1'b0, 16'd2, 16'd3, 4'b0000, "stop_low_cnt0");
    cyc(1'b0, STOP, 1'b0, 16'd2, 16'd3, 4'b0000, "idle_stop");

    // H=0, L=0: toggles every cycle
    for (int k = 0; k < 6; k++)
      cyc(1'b0, RUN, 1'b0, 16'd0, 16'd0, (k % 2 == 0) ? 4'b1101 : 4'b0011,
          $sformatf("run_h0l0_%0d", k));
    cyc(1'b0, STOP, 1'b0, 16'd0, 16'd0, 4'b0000, "stop_after_h0l0");

    // STOP in LOW with the counter still nonzero: IDLE next edge, no tick
    cyc(1'b0, RUN,  1'b0, 16'd1, 16'd4, 4'b1101, "h1l4_rise");
    cyc(1'b0, RUN,  1'b0, 16'd1, 16'd4, 4'b0011, "h1l4_fall");
    cyc(1'b0, RUN,  1'b0, 16'd1, 16'd4, 4'b0001, "h1l4_low");
    cyc(1'b0, STOP, 1'b0, 16'd1, 16'd4, 4'b0000, "stop_mid_low");

    // STEP, H=4: one pulse of 4 cycles; StepReq inside the pulse is ignored
    cyc(1'b0, STEP, 1'b1, 16'd4, 16'd3, 4'b1101, "step_rise");
    cyc(1'b0, STEP, 1'b0, 16'd4, 16'd3, 4'b1001, "step_high2");
    cyc(1'b0, STEP, 1'b1, 16'd4, 16'd3, 4'b1001, "step_high3_req_ignored");
    cyc(1'b0, STEP, 1'b0, 16'd4, 16'd3, 4'b1001, "step_high4");
    cyc(1'b0, STEP, 1'b0, 16'd4, 16'd3, 4'b0010, "step_fall");
    cyc(1'b0, STEP, 1'b0, 16'd4, 16'd3, 4'b0000, "step_idle");

    // STEP with StepReq held, H=1: pulses separated by one IDLE cycle
    cyc(1'b0, STEP, 1'b1, 16'd1, 16'd3, 4'b1101, "step_held_rise0");
    cyc(1'b0, STEP, 1'b1, 16'd1, 16'd3, 4'b0010, "step_held_idle0");
    cyc(1'b0, STEP, 1'b1, 16'd1, 16'd3, 4'b1101, "step_held_rise1");
    cyc(1'b0, STEP, 1'b0, 16'd1, 16'd3, 4'b0010, "step_held_idle1");
    cyc(1'b0, STEP, 1'b0, 16'd1, 16'd3, 4'b0000, "step_released");
    cyc(1'b0, RSVD, 1'b1, 16'd1, 16'd3, 4'b0000, "reserved_mode_stays_idle");

    // RUN H=8, STOP three cycles in: the high phase still lasts 8 cycles
    cyc(1'b0, RUN, 1'b0, 16'd8, 16'd2, 4'b1101, "h8_rise");
    cyc(1'b0, RUN, 1'b0, 16'd8, 16'd2, 4'b1001, "h8_high2");
    cyc(1'b0, RUN, 1'b0, 16'd8, 16'd2, 4'b1001, "h8_high3");
    for (int k = 4; k <= 8; k++)
      cyc(1'b0, STOP, 1'b0, 16'd8, 16'd2, 4'b1001, $sformatf("h8_stop_high%0d", k));
    cyc(1'b0, STOP, 1'b0, 16'd8, 16'd2, 4'b0010, "h8_fall_to_idle");
    cyc(1'b0, STOP, 1'b0, 16'd8, 16'd2, 4'b0000, "h8_idle");

    // Reset two cycles into a 5-cycle HIGH: outputs drop with no FallTick
    cyc(1'b0, RUN, 1'b0, 16'd5, 16'd2, 4'b1101, "h5_rise");
    cyc(1'b0, RUN, 1'b0, 16'd5, 16'd2, 4'b1001, "h5_high2");
    cyc(1'b1, RUN, 1'b0, 16'd5, 16'd2, 4'b0000, "h5_reset_mid_high");
    cyc(1'b0, RUN, 1'b0, 16'd5, 16'd2, 4'b1101, "h5_rise_after_reset");
    cyc(1'b0, RUN, 1'b0, 16'd5, 16'd2, 4'b1001, "h5_high_after_reset");
    cyc(1'b1, STOP, 1'b0, 16'd5, 16'd2, 4'b0000, "reset_again");

    // HighTicks 3 -> 6 mid-HIGH: current pulse 3 cycles, next pulse 6
    cyc(1'b0, RUN, 1'b0, 16'd3, 16'd1, 4'b1101, "hchg_rise");
    cyc(1'b0, RUN, 1'b0, 16'd6, 16'd1, 4'b1001, "hchg_high2");
    cyc(1'b0, RUN, 1'b0, 16'd6, 16'd1, 4'b1001, "hchg_high3");
    cyc(1'b0, RUN, 1'b0, 16'd6, 16'd1, 4'b0011, "hchg_fall");
    cyc(1'b0, RUN, 1'b0, 16'd6, 16'd1, 4'b1101, "hchg_rise2");
    for (int k = 2; k <= 6; k++)
      cyc(1'b0, RUN, 1'b0, 16'd6, 16'd1, 4'b1001, $sformatf("hchg_new_high%0d", k));
    cyc(1'b0, RUN,  1'b0, 16'd6, 16'd1, 4'b0011, "hchg_fall2");
    cyc(1'b0, STOP, 1'b0, 16'd6, 16'd1, 4'b0000, "hchg_stop");

    // Drain the scoreboard within a bounded number of cycles
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected samples never compared, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
